// File: rtl/countdown_timer.sv
// Countdown timer: mm:ss preset via increment pulses, counted down in 0.1 s ticks, expiry + timed beep.
// Latency: all outputs registered, one clk after the causing edge; no backpressure (pulse inputs, enable-gated).
// Optional preset reload on return to IDLE: define CD_PRESET_RELOAD_EN.
module countdown_timer #(
    parameter int CLOCKS4SECC = 10,
    parameter int BEEP_CYCLES = 200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       sw_start,
    input  logic       sw_clear,
    input  logic       sw_inc_min,
    input  logic       sw_inc_sec,
    output logic [5:0] min_cd,
    output logic [5:0] sec_cd,
    output logic [3:0] secc_cd,
    output logic       running,
    output logic       expired,
    output logic       beep
);
    localparam int PW = (CLOCKS4SECC > 1) ? $clog2(CLOCKS4SECC) : 1;
    localparam int BW = $clog2(BEEP_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_EXPIRED} state_t;

    state_t        r_state, w_state_nxt;
    logic [5:0]    r_min, r_sec;
    logic [3:0]    r_secc;
    logic [PW-1:0] r_presc;
    logic [BW-1:0] r_beep_cnt;
    logic          r_running, r_expired, r_beep;
    logic          w_running_nxt, w_expired_nxt;
    logic          w_clr, w_start, w_inc_min, w_inc_sec;
    logic          w_nonzero, w_tick, w_last, w_enter_idle;
    logic [5:0]    w_rl_min, w_rl_sec;
    logic [3:0]    w_rl_secc;

    // One action per cycle, in priority order clear > start > inc_min > inc_sec.
    assign w_clr     = enable & sw_clear;
    assign w_start   = enable & sw_start & ~sw_clear;
    assign w_inc_min = enable & sw_inc_min & ~sw_clear & ~sw_start;
    assign w_inc_sec = enable & sw_inc_sec & ~sw_clear & ~sw_start & ~sw_inc_min;

    assign w_nonzero    = |{r_min, r_sec, r_secc};
    assign w_tick       = (r_state == S_RUN) & ~w_clr & ~w_start & (r_presc == PW'(CLOCKS4SECC - 1));
    assign w_last       = w_tick & (r_min == 6'd0) & (r_sec == 6'd0) & (r_secc == 4'd1);
    assign w_enter_idle = (r_state != S_IDLE) & (w_state_nxt == S_IDLE);

`ifdef CD_PRESET_RELOAD_EN
    logic [5:0] r_pre_min, r_pre_sec;
    logic [3:0] r_pre_secc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre_min  <= '0;
            r_pre_sec  <= '0;
            r_pre_secc <= '0;
        end else if (r_state == S_IDLE && w_state_nxt == S_RUN) begin
            r_pre_min  <= r_min;
            r_pre_sec  <= r_sec;
            r_pre_secc <= r_secc;
        end
    end

    assign w_rl_min  = r_pre_min;
    assign w_rl_sec  = r_pre_sec;
    assign w_rl_secc = r_pre_secc;
`else
    assign w_rl_min  = '0;
    assign w_rl_sec  = '0;
    assign w_rl_secc = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= w_running_nxt;
            r_expired <= w_expired_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_start && w_nonzero) w_state_nxt = S_RUN;
            S_RUN:     if (w_clr)                w_state_nxt = S_IDLE;
                       else if (w_start)         w_state_nxt = S_PAUSE;
                       else if (w_last)          w_state_nxt = S_EXPIRED;
            S_PAUSE:   if (w_clr)                w_state_nxt = S_IDLE;
                       else if (w_start)         w_state_nxt = S_RUN;
            S_EXPIRED: if (w_clr || w_start)     w_state_nxt = S_IDLE;
            default:                             w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_running_nxt = (w_state_nxt == S_RUN);
        w_expired_nxt = (w_state_nxt == S_EXPIRED);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_min      <= '0;
            r_sec      <= '0;
            r_secc     <= '0;
            r_presc    <= '0;
            r_beep_cnt <= '0;
            r_beep     <= 1'b0;
        end else if (w_enter_idle) begin
            r_min      <= w_rl_min;
            r_sec      <= w_rl_sec;
            r_secc     <= w_rl_secc;
            r_presc    <= '0;
            r_beep_cnt <= '0;
            r_beep     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_inc_min) begin
                        r_min  <= (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
                        r_secc <= '0;
                    end else if (w_inc_sec) begin
                        r_sec  <= (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
                        r_secc <= '0;
                    end
                    if (w_state_nxt == S_RUN) r_presc <= '0;
                end
                S_RUN: begin
                    // The prescaler only advances on cycles that are not consumed by a start pulse.
                    if (w_tick) begin
                        r_presc <= '0;
                        if (r_secc != 4'd0) begin
                            r_secc <= r_secc - 4'd1;
                        end else if (r_sec != 6'd0) begin
                            r_secc <= 4'd9;
                            r_sec  <= r_sec - 6'd1;
                        end else begin
                            r_secc <= 4'd9;
                            r_sec  <= 6'd59;
                            r_min  <= r_min - 6'd1;
                        end
                        if (w_last) begin
                            r_beep     <= 1'b1;
                            r_beep_cnt <= BW'(BEEP_CYCLES - 1);
                        end
                    end else if (!w_start) begin
                        r_presc <= r_presc + PW'(1);
                    end
                end
                S_EXPIRED: begin
                    if (r_beep_cnt != '0) r_beep_cnt <= r_beep_cnt - BW'(1);
                    else                  r_beep     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign min_cd  = r_min;
    assign sec_cd  = r_sec;
    assign secc_cd = r_secc;
    assign running = r_running;
    assign expired = r_expired;
    assign beep    = r_beep;
endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed vector table, async-reset sequence, then random pulses vs a tenths-based model.
// Build with CD_PRESET_RELOAD_EN defined to exercise the preset-reload variant.
module tb_countdown_timer;
    localparam int C    = 10;
    localparam int BEEP = 200;

    logic       clk, reset_n, enable, sw_start, sw_clear, sw_inc_min, sw_inc_sec;
    logic [5:0] min_cd, sec_cd;
    logic [3:0] secc_cd;
    logic       running, expired, beep;

    int n_checks = 0;
    int n_pass   = 0;

    countdown_timer #(.CLOCKS4SECC(C), .BEEP_CYCLES(BEEP)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .sw_start(sw_start),
        .sw_clear(sw_clear), .sw_inc_min(sw_inc_min), .sw_inc_sec(sw_inc_sec),
        .min_cd(min_cd), .sec_cd(sec_cd), .secc_cd(secc_cd),
        .running(running), .expired(expired), .beep(beep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] ex(int m, int s, int c, bit r, bit x, bit b);
        return {6'(m), 6'(s), 4'(c), r, x, b};
    endfunction

`ifdef CD_PRESET_RELOAD_EN
    localparam logic [18:0] A_CLR = {6'd2, 6'd5, 4'd0, 3'b000};
    localparam logic [18:0] B_ACK = {6'd0, 6'd1, 4'd0, 3'b000};
    localparam logic [18:0] C_CLR = {6'd1, 6'd0, 4'd0, 3'b000};
    localparam logic [18:0] D_CLR = {6'd1, 6'd1, 4'd0, 3'b000};
`else
    localparam logic [18:0] A_CLR = '0;
    localparam logic [18:0] B_ACK = '0;
    localparam logic [18:0] C_CLR = '0;
    localparam logic [18:0] D_CLR = '0;
`endif

    typedef struct {
        bit          rst;
        bit          en, st, cl, im, is;
        int          n;
        logic [18:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit rst, bit en, bit st, bit cl, bit im, bit is, int n, logic [18:0] e);
        vec_t v;
        v.rst = rst; v.en = en; v.st = st; v.cl = cl; v.im = im; v.is = is; v.n = n; v.exp = e;
        tbl.push_back(v);
    endfunction

    function automatic logic [18:0] dut_out();
        return {min_cd, sec_cd, secc_cd, running, expired, beep};
    endfunction

    task automatic check(string name, logic [18:0] act, logic [18:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0d:%0d:%0d r%b x%b b%b, want %0d:%0d:%0d r%b x%b b%b", name,
                      act[18:13], act[12:7], act[6:3], act[2], act[1], act[0],
                      expv[18:13], expv[12:7], expv[6:3], expv[2], expv[1], expv[0]);
    endtask

    task automatic drive(bit en, bit st, bit cl, bit im, bit is);
        enable = en; sw_start = st; sw_clear = cl; sw_inc_min = im; sw_inc_sec = is;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(1, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Reference model: remaining time held as a plain count of tenths.
    int m_mode, m_t, m_phase, m_beep, m_pre;

    task automatic model_step(bit en, bit st, bit cl, bit im, bit is);
        bit a_cl, a_st, a_im, a_is;
        int mm, ss, reload;
        a_cl = en & cl;
        a_st = en & st & !cl;
        a_im = en & im & !cl & !st;
        a_is = en & is & !cl & !st & !im;
`ifdef CD_PRESET_RELOAD_EN
        reload = m_pre;
`else
        reload = 0;
`endif
        mm = m_t / 600;
        ss = (m_t / 10) % 60;
        case (m_mode)
            0: if (a_st) begin
                   if (m_t != 0) begin m_mode = 1; m_phase = 0; m_pre = m_t; end
               end else if (a_im) m_t = ((mm + 1) % 60) * 600 + ss * 10;
               else if (a_is)     m_t = mm * 600 + ((ss + 1) % 60) * 10;
            1: if (a_cl) begin m_mode = 0; m_t = reload; end
               else if (a_st) m_mode = 2;
               else begin
                   m_phase++;
                   if (m_phase == C) begin
                       m_phase = 0;
                       m_t--;
                       if (m_t == 0) begin m_mode = 3; m_beep = BEEP; end
                   end
               end
            2: if (a_cl) begin m_mode = 0; m_t = reload; end
               else if (a_st) m_mode = 1;
            default: if (a_cl || a_st) begin m_mode = 0; m_t = reload; m_beep = 0; end
                     else if (m_beep > 0) m_beep--;
        endcase
    endtask

    function automatic logic [18:0] model_out();
        return ex(m_t / 600, (m_t / 10) % 60, m_t % 10, m_mode == 1, m_mode == 3, m_beep > 0);
    endfunction

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0);

        // A: preset 02:05:0, count, clear+start collision
        add(1,0,0,0,0,0, 0, ex(0,0,0,0,0,0));
        add(0,1,0,0,1,0, 2, ex(2,0,0,0,0,0));
        add(0,1,0,0,0,1, 5, ex(2,5,0,0,0,0));
        add(0,1,1,0,0,0, 1, ex(2,5,0,1,0,0));
        add(0,1,0,0,0,0,10, ex(2,4,9,1,0,0));
        add(0,1,0,0,0,0,50, ex(2,4,4,1,0,0));
        add(0,1,1,1,0,0, 1, A_CLR);
        // B: 00:01:0 to expiry, beep length, acknowledge
        add(1,0,0,0,0,0, 0, ex(0,0,0,0,0,0));
        add(0,1,0,0,0,1, 1, ex(0,1,0,0,0,0));
        add(0,1,1,0,0,0, 1, ex(0,1,0,1,0,0));
        add(0,1,0,0,0,0,10, ex(0,0,9,1,0,0));
        add(0,1,0,0,0,0,89, ex(0,0,1,1,0,0));
        add(0,1,0,0,0,0, 1, ex(0,0,0,0,1,1));
        add(0,1,0,0,0,0,199,ex(0,0,0,0,1,1));
        add(0,1,0,0,0,0, 1, ex(0,0,0,0,1,0));
        add(0,1,0,0,0,1, 1, ex(0,0,0,0,1,0));
        add(0,0,1,0,0,0, 1, ex(0,0,0,0,1,0));
        add(0,1,1,0,0,0, 1, B_ACK);
        // C: borrow chain, pause/resume prescaler hold, enable gating, clear
        add(1,0,0,0,0,0, 0, ex(0,0,0,0,0,0));
        add(0,1,0,0,1,0, 1, ex(1,0,0,0,0,0));
        add(0,1,1,0,0,0, 1, ex(1,0,0,1,0,0));
        add(0,1,0,0,0,0,10, ex(0,59,9,1,0,0));
        add(0,1,0,0,0,0, 3, ex(0,59,9,1,0,0));
        add(0,1,1,0,0,0, 1, ex(0,59,9,0,0,0));
        add(0,1,0,0,0,0,40, ex(0,59,9,0,0,0));
        add(0,1,0,0,0,1, 1, ex(0,59,9,0,0,0));
        add(0,1,1,0,0,0, 1, ex(0,59,9,1,0,0));
        add(0,1,0,0,0,0, 6, ex(0,59,9,1,0,0));
        add(0,1,0,0,0,0, 1, ex(0,59,8,1,0,0));
        add(0,0,1,0,0,0, 1, ex(0,59,8,1,0,0));
        add(0,1,0,0,0,0, 9, ex(0,59,7,1,0,0));
        add(0,1,0,0,0,1, 1, ex(0,59,7,1,0,0));
        add(0,1,0,1,0,0, 1, C_CLR);
        // D: zero start ignored, wraps, priority
        add(1,0,0,0,0,0, 0, ex(0,0,0,0,0,0));
        add(0,1,1,0,0,0, 1, ex(0,0,0,0,0,0));
        add(0,1,0,0,0,1,60, ex(0,0,0,0,0,0));
        add(0,1,0,0,0,1, 1, ex(0,1,0,0,0,0));
        add(0,1,0,0,1,0,60, ex(0,1,0,0,0,0));
        add(0,1,0,0,1,1, 1, ex(1,1,0,0,0,0));
        add(0,1,1,0,1,0, 1, ex(1,1,0,1,0,0));
        add(0,1,0,1,0,0, 1, D_CLR);
        // E: set up 00:30:5 in RUN for the async reset sequence
        add(1,0,0,0,0,0, 0, ex(0,0,0,0,0,0));
        add(0,1,0,0,0,1,31, ex(0,31,0,0,0,0));
        add(0,1,1,0,0,0, 1, ex(0,31,0,1,0,0));
        add(0,1,0,0,0,0,50, ex(0,30,5,1,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            else begin
                drive(tbl[i].en, tbl[i].st, tbl[i].cl, tbl[i].im, tbl[i].is);
                repeat (tbl[i].n) begin
                    @(posedge clk);
                    #1;
                end
                drive(1, 0, 0, 0, 0);
            end
            check($sformatf("row%0d", i), dut_out(), tbl[i].exp);
        end

        // Asynchronous reset mid-run: outputs clear without a clock edge.
        #2 reset_n = 1'b0;
        #1 check("async_rst", dut_out(), ex(0,0,0,0,0,0));
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1 check("post_rst_idle", dut_out(), ex(0,0,0,0,0,0));

        // Random pulses against the model.
        do_reset();
        m_mode = 0; m_t = 0; m_phase = 0; m_beep = 0; m_pre = 0;
        for (int k = 0; k < 8000; k++) begin
            bit en, st, cl, im, is;
            en = ($urandom_range(0, 9) != 0);
            st = ($urandom_range(0, 199) == 0);
            cl = ($urandom_range(0, 1499) == 0);
            im = ($urandom_range(0, 399) == 0);
            is = ($urandom_range(0, 5) == 0);
            drive(en, st, cl, im, is);
            @(posedge clk);
            model_step(en, st, cl, im, is);
            #1 check($sformatf("rand%0d", k), dut_out(), model_out());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
